axi_rd_burst_chop: RTL and testbench
====================================

Name: axi_rd_burst_chop

Overview:
- Sits directly upstream of the AXI read path, between the AXI4 interconnect and its read-address/read-data ports.
- Splits each incoming INCR read burst (up to 256 beats) into sub-bursts of at most CHOP_BEATS beats, issued in order, one at a time.
- On the return path it suppresses RLAST on every sub-burst except the final one, so the upstream master sees one burst per AR.

Parameters:
ADDRS, 32, address width in bits
WIDTH, 32, data width in bits; MASKS = WIDTH/8 bytes per beat
AXI_ID_WIDTH, 4, ID width
CHOP_BEATS, 16, maximum beats per sub-burst (power of two, 1..256)
FLAG_DEPTH, 16, depth of the last-sub-burst flag FIFO (power of two)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
s_arvalid_i  in  1  upstream AR valid
s_arready_o  out  1  upstream AR ready
s_araddr_i  in  ADDRS  burst start address (MASKS-aligned)
s_arid_i  in  AXI_ID_WIDTH  burst ID
s_arlen_i  in  8  beats-1
s_arburst_i  in  2  must be INCR (2'b01)
s_rvalid_o / s_rready_i / s_rlast_o  out/in/out  1 each  upstream R handshake and merged last
s_rresp_o  out  2  passthrough of m_rresp_i
s_rid_o  out  AXI_ID_WIDTH  passthrough of m_rid_i
s_rdata_o  out  WIDTH  passthrough of m_rdata_i
m_arvalid_o / m_arready_i  out/in  1 each  downstream AR handshake
m_araddr_o / m_arid_o / m_arlen_o / m_arburst_o  out  ADDRS/AXI_ID_WIDTH/8/2  sub-burst request; arburst is always 2'b01
m_rvalid_i / m_rready_o / m_rlast_i  in/out/in  1 each  downstream R handshake
m_rresp_i / m_rid_i / m_rdata_i  in  2/AXI_ID_WIDTH/WIDTH  downstream R payload

Behaviour:
- Reset (reset low, asynchronous): state=ST_IDLE; s_arready_o=0; m_arvalid_o=0; flag FIFO empty; s_arready_o rises 1 cycle after reset deasserts.
- Registers: addr_q (ADDRS), id_q, rem_q (9 bits, beats remaining, 1..256).
- ST_IDLE: s_arready_o=1.
  - On s_arvalid_i & s_arready_o: capture addr_q, id_q, rem_q=arlen+1; s_arready_o<=0; go to ST_ISSUE.
- ST_ISSUE: m_arvalid_o=1 while the flag FIFO is not full; otherwise m_arvalid_o=0 until a pop occurs.
  - m_araddr_o=addr_q; m_arid_o=id_q; m_arlen_o=min(rem_q,CHOP_BEATS)-1.
  - On m_arvalid_o & m_arready_i: push flag final=(rem_q<=CHOP_BEATS); addr_q+=CHOP_BEATS*MASKS (modulo 2^ADDRS); rem_q-=CHOP_BEATS.
  - If final: m_arvalid_o<=0, s_arready_o<=1, go to ST_IDLE. No bubble beyond this 1 cycle between upstream bursts.
- AR outputs are registered and hold stable while m_arvalid_o=1 and m_arready_i=0 (AXI rule).
- R channel is combinational passthrough:
  - s_rvalid_o=m_rvalid_i; m_rready_o=s_rready_i; data/id/resp pass through.
  - s_rlast_o = m_rlast_i & flag_head.
  - Pop the flag FIFO on m_rvalid_i & m_rready_o & m_rlast_i.
- A push and a pop in the same cycle are both performed; the occupancy count is unchanged. A pop while the FIFO is empty is a protocol error: assert in simulation, no state change.
- Downstream returns sub-bursts in issue order (single-ID in-order path). No reordering across IDs.
- Non-INCR s_arburst_i: simulation $error/$fatal; hardware treats it as INCR.
- 4 kB crossing is the master's responsibility; this block does not check it.
- Throughput: ceil((arlen+1)/CHOP_BEATS) AR handshakes per upstream burst. With m_arready_i held at 1, sub-bursts issue on consecutive cycles.
- Mid-operation reset: all state is discarded immediately and outputs return to their reset values. Any in-flight R beats are the system's responsibility to flush.

Test Plan:
- CHOP_BEATS=16, araddr=0x1000, arlen=0 -> one m_ AR with addr 0x1000, len 0; the single R beat has s_rlast_o=1.
- arlen=63, araddr=0x2000 -> 4 ARs: 0x2000, 0x2040, 0x2080, 0x20C0, each len 15. 64 R beats with s_rlast_o=1 only on beat 64. s_arready_o low for 5 cycles.
- arlen=40 -> ARs with lens 15, 15, 8 at +0x00, +0x40, +0x80. s_rlast_o only on beat 41.
- m_arready_i low for 7 cycles during the second sub-burst -> m_araddr_o and m_arlen_o hold stable; the issue sequence continues unchanged afterwards.
- FLAG_DEPTH=4, arlen=255, no R returned -> exactly 4 ARs issued, then m_arvalid_o=0. After one full sub-burst of R beats completes, a 5th AR issues.
- Pull reset low mid-ST_ISSUE with rem_q=100 -> m_arvalid_o=0 and s_arready_o=0 immediately. One cycle after release, s_arready_o=1 and the FIFO is empty.

Source files
------------

// File: rtl/axi_rd_burst_chop.sv
`default_nettype none
// ============================================================================
// Module  : axi_rd_burst_chop
// Brief   : Splits AXI4 INCR read bursts into sub-bursts of at most CHOP_BEATS
//           beats and merges RLAST so the master sees one burst per AR.
// Rev     : 1.0
// ============================================================================
module axi_rd_burst_chop #(
   parameter int ADDRS        = 32,
   parameter int WIDTH        = 32,
   parameter int AXI_ID_WIDTH = 4,
   parameter int CHOP_BEATS   = 16,
   parameter int FLAG_DEPTH   = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    s_arvalid_i,
   output logic                    s_arready_o,
   input  logic [ADDRS-1:0]        s_araddr_i,
   input  logic [AXI_ID_WIDTH-1:0] s_arid_i,
   input  logic [7:0]              s_arlen_i,
   input  logic [1:0]              s_arburst_i,
   output logic                    s_rvalid_o,
   input  logic                    s_rready_i,
   output logic                    s_rlast_o,
   output logic [1:0]              s_rresp_o,
   output logic [AXI_ID_WIDTH-1:0] s_rid_o,
   output logic [WIDTH-1:0]        s_rdata_o,
   output logic                    m_arvalid_o,
   input  logic                    m_arready_i,
   output logic [ADDRS-1:0]        m_araddr_o,
   output logic [AXI_ID_WIDTH-1:0] m_arid_o,
   output logic [7:0]              m_arlen_o,
   output logic [1:0]              m_arburst_o,
   input  logic                    m_rvalid_i,
   output logic                    m_rready_o,
   input  logic                    m_rlast_i,
   input  logic [1:0]              m_rresp_i,
   input  logic [AXI_ID_WIDTH-1:0] m_rid_i,
   input  logic [WIDTH-1:0]        m_rdata_i
);

   localparam int               MASKS   = WIDTH / 8;
   localparam int               PW      = (FLAG_DEPTH > 1) ? $clog2(FLAG_DEPTH) : 1;
   localparam logic [8:0]       C_CHOP  = 9'(CHOP_BEATS);
   localparam logic [ADDRS-1:0] C_STEP  = ADDRS'(CHOP_BEATS * MASKS);
   localparam logic [PW:0]      C_DEPTH = (PW + 1)'(FLAG_DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic                    s_arready_q, s_arready_d;
   logic                    m_arvalid_q, m_arvalid_d;
   logic [ADDRS-1:0]        addr_q, addr_d;
   logic [AXI_ID_WIDTH-1:0] id_q, id_d;
   logic [8:0]              rem_q, rem_d;
   logic [7:0]              arlen_q, arlen_d;
   logic [FLAG_DEPTH-1:0]   flags_q, flags_d;
   logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]             cnt_q, cnt_d;

   logic w_ar_fire, w_final, w_push, w_pop_req, w_pop, w_empty, w_head;

   function automatic logic [7:0] sub_len(input logic [8:0] rem);
      return (rem > C_CHOP) ? 8'(C_CHOP - 9'd1) : 8'(rem - 9'd1);
   endfunction

   assign w_ar_fire = m_arvalid_q & m_arready_i;
   assign w_final   = (rem_q <= C_CHOP);
   assign w_push    = w_ar_fire;
   assign w_pop_req = m_rvalid_i & s_rready_i & m_rlast_i;
   assign w_empty   = (cnt_q == '0);
   assign w_pop     = w_pop_req & ~w_empty;
   assign w_head    = flags_q[rd_q];

   always_comb begin
      state_d     = state_q;
      s_arready_d = s_arready_q;
      m_arvalid_d = m_arvalid_q;
      addr_d      = addr_q;
      id_d        = id_q;
      rem_d       = rem_q;
      arlen_d     = arlen_q;
      flags_d     = flags_q;
      wr_d        = wr_q;
      rd_d        = rd_q;

      // Flag FIFO: one entry per issued sub-burst, set when it is the last one
      if (w_push) begin
         flags_d[wr_q] = w_final;
         wr_d          = wr_q + 1'b1;
      end
      if (w_pop) begin
         rd_d = rd_q + 1'b1;
      end
      cnt_d = cnt_q + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};

      case (state_q)
         ST_IDLE: begin
            s_arready_d = 1'b1;
            m_arvalid_d = 1'b0;
            if (s_arvalid_i && s_arready_q) begin
               addr_d      = s_araddr_i;
               id_d        = s_arid_i;
               rem_d       = {1'b0, s_arlen_i} + 9'd1;
               arlen_d     = sub_len({1'b0, s_arlen_i} + 9'd1);
               s_arready_d = 1'b0;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (w_ar_fire && w_final) begin
               m_arvalid_d = 1'b0;
               s_arready_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               if (w_ar_fire) begin
                  addr_d  = addr_q + C_STEP;
                  rem_d   = rem_q - C_CHOP;
                  arlen_d = sub_len(rem_q - C_CHOP);
               end
               // Valid can only rise here, never drop without a handshake:
               // occupancy cannot grow while a request is pending.
               m_arvalid_d = (cnt_d != C_DEPTH);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         s_arready_q <= 1'b0;
         m_arvalid_q <= 1'b0;
         addr_q      <= '0;
         id_q        <= '0;
         rem_q       <= '0;
         arlen_q     <= '0;
         flags_q     <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         s_arready_q <= s_arready_d;
         m_arvalid_q <= m_arvalid_d;
         addr_q      <= addr_d;
         id_q        <= id_d;
         rem_q       <= rem_d;
         arlen_q     <= arlen_d;
         flags_q     <= flags_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
      end
   end

   assign s_arready_o = s_arready_q;
   assign m_arvalid_o = m_arvalid_q;
   assign m_araddr_o  = addr_q;
   assign m_arid_o    = id_q;
   assign m_arlen_o   = arlen_q;
   assign m_arburst_o = 2'b01;

   assign s_rvalid_o  = m_rvalid_i;
   assign m_rready_o  = s_rready_i;
   assign s_rdata_o   = m_rdata_i;
   assign s_rid_o     = m_rid_i;
   assign s_rresp_o   = m_rresp_i;
   assign s_rlast_o   = m_rlast_i & w_head & ~w_empty;

   always @(posedge clock) begin
      if (reset && s_arvalid_i && s_arready_q)
         assert (s_arburst_i == 2'b01) else $error("axi_rd_burst_chop: non-INCR read burst");
      if (reset && w_pop_req)
         assert (!w_empty) else $error("axi_rd_burst_chop: RLAST with no outstanding sub-burst");
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_burst_chop.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_rd_burst_chop
// Brief   : Self-checking bench for axi_rd_burst_chop with a randomized
//           downstream slave and a burst-level expected-result model.
// Rev     : 1.0
// ============================================================================
module tb_axi_rd_burst_chop;
   localparam int ADDRS = 32;
   localparam int WIDTH = 32;
   localparam int IDW   = 4;
   localparam int CB    = 16;
   localparam int DEPTH = 4;
   localparam int BYTES = WIDTH / 8;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             s_arvalid_i = 1'b0, s_arready_o;
   logic [ADDRS-1:0] s_araddr_i = '0;
   logic [IDW-1:0]   s_arid_i = '0;
   logic [7:0]       s_arlen_i = '0;
   logic [1:0]       s_arburst_i = 2'b01;
   logic             s_rvalid_o, s_rready_i, s_rlast_o;
   logic [1:0]       s_rresp_o;
   logic [IDW-1:0]   s_rid_o;
   logic [WIDTH-1:0] s_rdata_o;
   logic             m_arvalid_o, m_arready_i;
   logic [ADDRS-1:0] m_araddr_o;
   logic [IDW-1:0]   m_arid_o;
   logic [7:0]       m_arlen_o;
   logic [1:0]       m_arburst_o;
   logic             m_rvalid_i, m_rready_o, m_rlast_i;
   logic [1:0]       m_rresp_i;
   logic [IDW-1:0]   m_rid_i;
   logic [WIDTH-1:0] m_rdata_i;

   axi_rd_burst_chop #(
      .ADDRS(ADDRS), .WIDTH(WIDTH), .AXI_ID_WIDTH(IDW),
      .CHOP_BEATS(CB), .FLAG_DEPTH(DEPTH)
   ) dut (
      .clock(clock), .reset(reset),
      .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o), .s_araddr_i(s_araddr_i),
      .s_arid_i(s_arid_i), .s_arlen_i(s_arlen_i), .s_arburst_i(s_arburst_i),
      .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i), .s_rlast_o(s_rlast_o),
      .s_rresp_o(s_rresp_o), .s_rid_o(s_rid_o), .s_rdata_o(s_rdata_o),
      .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_araddr_o(m_araddr_o),
      .m_arid_o(m_arid_o), .m_arlen_o(m_arlen_o), .m_arburst_o(m_arburst_o),
      .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rlast_i(m_rlast_i),
      .m_rresp_i(m_rresp_i), .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [3:0]  id;
   } ar_t;

   typedef struct packed {
      logic        last;
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } rb_t;

   ar_t ar_log[$];
   ar_t pend[$];
   ar_t bursts[$];
   rb_t r_log[$];
   int  ar_mode = 1;
   bit  r_en = 1'b0;
   int  checks = 0;
   int  failures = 0;

   // Downstream slave: drives at negedge, records handshakes 1 ns later
   initial begin : slave
      int beat;
      bit fired;
      beat = 0; fired = 1'b0;
      m_arready_i = 1'b0; m_rvalid_i = 1'b0; m_rlast_i = 1'b0;
      m_rdata_i = '0; m_rid_i = '0; m_rresp_i = '0; s_rready_i = 1'b0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            pend.delete();
            beat = 0; fired = 1'b0;
            m_arready_i = 1'b0; m_rvalid_i = 1'b0; m_rlast_i = 1'b0; s_rready_i = 1'b0;
         end else begin
            case (ar_mode)
               0:       m_arready_i = 1'b0;
               1:       m_arready_i = 1'b1;
               default: m_arready_i = 1'($urandom_range(0, 1));
            endcase
            if (fired || !m_rvalid_i) begin
               m_rvalid_i = 1'b0;
               m_rlast_i  = 1'b0;
               if (r_en && pend.size() > 0 && $urandom_range(0, 3) != 0) begin
                  m_rvalid_i = 1'b1;
                  m_rdata_i  = $urandom;
                  m_rresp_i  = 2'($urandom_range(0, 3));
                  m_rid_i    = pend[0].id;
                  m_rlast_i  = (beat == int'(pend[0].len));
               end
            end
            s_rready_i = r_en && ($urandom_range(0, 3) != 0);
            fired = 1'b0;
            #1;
            if (m_arvalid_o && m_arready_i) begin
               ar_log.push_back({m_araddr_o, m_arlen_o, m_arid_o});
               pend.push_back({m_araddr_o, m_arlen_o, m_arid_o});
            end
            if (m_rvalid_i && m_rready_o) begin
               fired = 1'b1;
               r_log.push_back({s_rlast_o, s_rid_o, s_rdata_o, s_rresp_o, m_rdata_i, m_rresp_i});
               if (m_rlast_i) begin
                  void'(pend.pop_front());
                  beat = 0;
               end else begin
                  beat++;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input bit wait_ready, output int lowcnt, output bit ok);
      @(negedge clock);
      s_arvalid_i = 1'b1; s_araddr_i = addr; s_arlen_i = len; s_arid_i = id; s_arburst_i = 2'b01;
      ok = 1'b0; lowcnt = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         #2;
         if (s_arready_o) ok = 1'b1;
         else @(negedge clock);
      end
      @(negedge clock);
      s_arvalid_i = 1'b0;
      if (wait_ready) begin
         for (int i = 0; i < 2000; i++) begin
            #2;
            if (s_arready_o) break;
            lowcnt++;
            @(negedge clock);
         end
      end
      bursts.push_back({addr, len, id});
   endtask

   // Expected sub-bursts and beats derived from the recorded upstream bursts
   task automatic check_logs(input string name);
      ar_t         exp_ar[$];
      bit          exp_last[$];
      logic [3:0]  exp_id[$];
      foreach (bursts[b]) begin
         int          n;
         logic [31:0] a;
         n = int'(bursts[b].len) + 1;
         a = bursts[b].addr;
         while (n > 0) begin
            int l;
            l = (n > CB) ? CB : n;
            exp_ar.push_back({a, 8'(l - 1), bursts[b].id});
            a += 32'(CB * BYTES);
            n -= l;
         end
         for (int i = 0; i <= int'(bursts[b].len); i++) begin
            exp_last.push_back(i == int'(bursts[b].len));
            exp_id.push_back(bursts[b].id);
         end
      end
      for (int i = 0; i < 20000 && r_log.size() < exp_last.size(); i++) @(negedge clock);
      repeat (4) @(negedge clock);
      checks++;
      if (r_log.size() != exp_last.size()) begin
         failures++;
         $display("FAIL %s r_beat_count got=%0d exp=%0d", name, r_log.size(), exp_last.size());
      end
      checks++;
      if (ar_log.size() != exp_ar.size()) begin
         failures++;
         $display("FAIL %s ar_count got=%0d exp=%0d", name, ar_log.size(), exp_ar.size());
      end
      for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++) begin
         checks++;
         if (ar_log[i] !== exp_ar[i]) begin
            failures++;
            $display("FAIL %s ar[%0d] got addr=%h len=%0d id=%0d exp addr=%h len=%0d id=%0d", name, i,
                     ar_log[i].addr, ar_log[i].len, ar_log[i].id, exp_ar[i].addr, exp_ar[i].len, exp_ar[i].id);
         end
      end
      for (int i = 0; i < exp_last.size() && i < r_log.size(); i++) begin
         checks++;
         if ({r_log[i].last, r_log[i].id, r_log[i].data, r_log[i].resp} !==
             {exp_last[i], exp_id[i], r_log[i].exp_data, r_log[i].exp_resp}) begin
            failures++;
            $display("FAIL %s beat[%0d] got last=%0b id=%0d data=%h resp=%0d exp last=%0b id=%0d data=%h resp=%0d",
                     name, i, r_log[i].last, r_log[i].id, r_log[i].data, r_log[i].resp,
                     exp_last[i], exp_id[i], r_log[i].exp_data, r_log[i].exp_resp);
         end
      end
      bursts.delete(); ar_log.delete(); r_log.delete();
   endtask

   task automatic check_ok(input string name, input bit ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s ar_accept got=timeout exp=accepted", name);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      #2;
      checks++;
      if (s_arready_o !== 1'b0 || m_arvalid_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold got arready=%b arvalid=%b exp 0 0", s_arready_o, m_arvalid_o);
      end
      @(negedge clock);
      reset = 1'b1;
      #2;
      checks++;
      if (s_arready_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_early got arready=%b exp 0", s_arready_o);
      end
      @(negedge clock);
      #2;
      checks++;
      if (s_arready_o !== 1'b1 || m_arvalid_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_next got arready=%b arvalid=%b exp 1 0", s_arready_o, m_arvalid_o);
      end
   endtask

   task automatic test_single();
      int lc; bit ok;
      ar_mode = 1; r_en = 1'b1;
      send_ar(32'h1000, 8'd0, 4'h3, 1'b1, lc, ok);
      check_ok("single", ok);
      check_logs("single");
   endtask

   task automatic test_four();
      int lc; bit ok;
      ar_mode = 1; r_en = 1'b1;
      send_ar(32'h2000, 8'd63, 4'h5, 1'b1, lc, ok);
      check_ok("four", ok);
      checks++;
      if (lc != 5) begin
         failures++;
         $display("FAIL four arready_low_cycles got=%0d exp=5", lc);
      end
      check_logs("four");
   endtask

   task automatic test_len41();
      int lc; bit ok;
      ar_mode = 2; r_en = 1'b1;
      send_ar(32'h7000, 8'd40, 4'h9, 1'b1, lc, ok);
      check_ok("len41", ok);
      check_logs("len41");
   endtask

   task automatic test_stall();
      int lc; bit ok;
      ar_mode = 0; r_en = 1'b1;
      send_ar(32'h3000, 8'd47, 4'h1, 1'b0, lc, ok);
      check_ok("stall", ok);
      #2;
      for (int i = 0; i < 20 && m_arvalid_o !== 1'b1; i++) begin @(negedge clock); #2; end
      ar_mode = 1;
      @(negedge clock); #2;
      ar_mode = 0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clock); #2;
         checks++;
         if (m_arvalid_o !== 1'b1 || m_araddr_o !== 32'h3040 || m_arlen_o !== 8'd15) begin
            failures++;
            $display("FAIL stall_hold[%0d] got valid=%b addr=%h len=%0d exp 1 00003040 15",
                     k, m_arvalid_o, m_araddr_o, m_arlen_o);
         end
      end
      ar_mode = 2;
      check_logs("stall");
   endtask

   task automatic test_flag_full();
      int lc, rc; bit ok;
      ar_mode = 1; r_en = 1'b0;
      send_ar(32'h4000, 8'd255, 4'h2, 1'b0, lc, ok);
      check_ok("flag_full", ok);
      repeat (20) @(negedge clock);
      #2;
      checks++;
      if (ar_log.size() != DEPTH || m_arvalid_o !== 1'b0) begin
         failures++;
         $display("FAIL flag_full_stop got ars=%0d arvalid=%b exp %0d 0", ar_log.size(), m_arvalid_o, DEPTH);
      end
      r_en = 1'b1;
      for (int i = 0; i < 3000 && ar_log.size() < DEPTH + 1; i++) begin @(negedge clock); #2; end
      rc = r_log.size();
      checks++;
      if (ar_log.size() != DEPTH + 1 || rc < CB || rc >= 2 * CB) begin
         failures++;
         $display("FAIL flag_full_resume got ars=%0d beats_before=%0d exp ars=%0d beats in [%0d,%0d)",
                  ar_log.size(), rc, DEPTH + 1, CB, 2 * CB);
      end
      check_logs("flag_full");
   endtask

   task automatic test_reset_mid();
      int lc; bit ok;
      ar_mode = 0; r_en = 1'b0;
      send_ar(32'h5000, 8'd147, 4'h6, 1'b0, lc, ok);
      check_ok("reset_mid", ok);
      #2;
      for (int i = 0; i < 20 && m_arvalid_o !== 1'b1; i++) begin @(negedge clock); #2; end
      ar_mode = 1;
      repeat (3) @(negedge clock);
      #2;
      ar_mode = 0;
      @(negedge clock); #2;
      checks++;
      if (ar_log.size() != 3 || m_arvalid_o !== 1'b1 || m_araddr_o !== 32'h50C0) begin
         failures++;
         $display("FAIL reset_mid_pre got ars=%0d arvalid=%b addr=%h exp 3 1 000050c0",
                  ar_log.size(), m_arvalid_o, m_araddr_o);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (m_arvalid_o !== 1'b0 || s_arready_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_async got arvalid=%b arready=%b exp 0 0", m_arvalid_o, s_arready_o);
      end
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock); #2;
      checks++;
      if (s_arready_o !== 1'b1 || m_arvalid_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_release got arready=%b arvalid=%b exp 1 0", s_arready_o, m_arvalid_o);
      end
      bursts.delete(); ar_log.delete(); r_log.delete();
      ar_mode = 1;
      send_ar(32'h6000, 8'd63, 4'h7, 1'b1, lc, ok);
      check_ok("post_reset", ok);
      checks++;
      if (lc != 5 || ar_log.size() != DEPTH) begin
         failures++;
         $display("FAIL post_reset_fifo_empty got low=%0d ars=%0d exp 5 %0d", lc, ar_log.size(), DEPTH);
      end
      r_en = 1'b1;
      check_logs("post_reset");
   endtask

   task automatic test_back_to_back();
      int lc1, lc2; bit ok1, ok2;
      ar_mode = 1; r_en = 1'b1;
      send_ar(32'h8000, 8'd15, 4'h1, 1'b1, lc1, ok1);
      send_ar(32'h8100, 8'd20, 4'h2, 1'b1, lc2, ok2);
      check_ok("b2b_first", ok1);
      check_ok("b2b_second", ok2);
      checks++;
      if (lc1 != 2 || lc2 != 3) begin
         failures++;
         $display("FAIL b2b_arready_low got=%0d,%0d exp=2,3", lc1, lc2);
      end
      check_logs("back_to_back");
   endtask

   task automatic test_random();
      int lc; bit ok;
      for (int t = 0; t < 6; t++) begin
         ar_mode = 2; r_en = 1'b1;
         send_ar($urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                 1'b1, lc, ok);
         check_ok("random", ok);
         check_logs("random");
      end
   endtask

   initial begin : main
      test_reset();
      test_single();
      test_four();
      test_len41();
      test_stall();
      test_flag_full();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
